// File: rtl/negedge_detector_pkg.sv
// Shared constants for the falling-edge detector: state width and the
// one-hot state encodings used by the FSM.
package negedge_detector_pkg;

  localparam int STATE_W = 4;

  // One-hot state codes. Any other value is illegal and recovers to IDLE.
  localparam logic [STATE_W-1:0] IDLE = 4'b0001;  // just out of reset, no prior sample
  localparam logic [STATE_W-1:0] HIGH = 4'b0010;  // last sample was 1
  localparam logic [STATE_W-1:0] FALL = 4'b0100;  // 1 -> 0 just seen, Y asserted
  localparam logic [STATE_W-1:0] LOW  = 4'b1000;  // last sample was 0, no pulse

endpackage

// File: rtl/negedge_detector.sv
// Moore falling-edge detector. Converts a level input into a single-cycle
// pulse on Y one clock after a sampled 1 -> 0 transition on I. The state
// register is named present_state so it can be probed hierarchically.
//
// Handshake note: there is no valid/ready interface; I is a plain level
// sampled on every rising clk edge, and Y is a registered-state decode that
// is valid for the whole cycle following the edge that detected the fall.
module negedge_detector
  import negedge_detector_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic I,
  output logic Y
);

  logic [STATE_W-1:0] present_state;
  logic [STATE_W-1:0] w_next_state;

  // Next-state logic: full decode of all 16 codes, illegal codes go to IDLE.
  always_comb begin
    w_next_state = IDLE;
    case (present_state)
      IDLE:    w_next_state = I ? HIGH : LOW;
      HIGH:    w_next_state = I ? HIGH : FALL;
      FALL:    w_next_state = I ? HIGH : LOW;
      LOW:     w_next_state = I ? HIGH : LOW;
      default: w_next_state = IDLE;
    endcase
  end

  // State register with synchronous active-high reset taking priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      present_state <= IDLE;
    end else begin
      present_state <= w_next_state;
    end
  end

  // Moore output: pulse only while in FALL, no path from I to Y.
  always_comb begin
    Y = (present_state == FALL);
  end

endmodule

// File: tb/tb_negedge_detector.sv
// Self-checking bench for negedge_detector: directed scenarios with literal
// expectations, randomized input with occasional resets, and an illegal
// state injection, all compared against a sample-history reference model.
module tb_negedge_detector;

  logic clk;
  logic reset;
  logic I;
  logic Y;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: remembers the previous sampled input and whether one
  // exists since reset, and derives the expected state/pulse from them.
  logic       m_valid    = 1'b0;
  logic       m_has_prev = 1'b0;
  logic       m_prev_i   = 1'b0;
  logic [3:0] m_state    = 4'b0001;
  logic       m_y        = 1'b0;
  logic       inj_on     = 1'b0;

  negedge_detector dut (
    .clk   (clk),
    .reset (reset),
    .I     (I),
    .Y     (Y)
  );

  // Clock and initial levels
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at t=%0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  // Model update on every rising edge
  always @(posedge clk) begin
    logic fell;
    if (inj_on) begin
      m_state    = 4'b0001;
      m_y        = 1'b0;
      m_has_prev = 1'b0;
    end else if (reset) begin
      m_state    = 4'b0001;
      m_y        = 1'b0;
      m_has_prev = 1'b0;
    end else begin
      fell       = m_has_prev && m_prev_i && !I;
      m_y        = fell;
      m_state    = I ? 4'b0010 : (fell ? 4'b0100 : 4'b1000);
      m_has_prev = 1'b1;
      m_prev_i   = I;
    end
    m_valid = 1'b1;
  end

  // Scoreboard compare on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (m_valid) begin
      if (inj_on) begin
        check("cmp_state_illegal", dut.present_state, 4'b0110);
        check("cmp_y_illegal", {3'b000, Y}, 4'b0000);
      end else begin
        check("cmp_state", dut.present_state, m_state);
        check("cmp_y", {3'b000, Y}, {3'b000, m_y});
      end
    end
  end

  task automatic drive(input logic vi, input logic vr);
    @(negedge clk);
    I     = vi;
    reset = vr;
  endtask

  task automatic peek(input string name, input logic [3:0] es, input logic ey);
    @(posedge clk);
    #2;
    check({name, "_state"}, dut.present_state, es);
    check({name, "_y"}, {3'b000, Y}, {3'b000, ey});
  endtask

  // Stimulus
  initial begin
    I     = 1'b1;
    reset = 1'b1;
    // Reset with a glitch on I straddling edge 5
    #3 I = 1'b0;
    #4 check("rst_state", dut.present_state, 4'b0001);       // t=7
       check("rst_y", {3'b000, Y}, 4'b0000);
    #1 I = 1'b1;                                              // t=8
    #2 reset = 1'b0;                                          // t=10
    // Steady high then a falling edge
    #10 check("high15_state", dut.present_state, 4'b0010);   // t=20
    #20 check("high35_state", dut.present_state, 4'b0010);   // t=40
    #13 I = 1'b0;                                             // t=53
    #5  check("fall55_state", dut.present_state, 4'b0100);   // t=58
        check("fall55_y", {3'b000, Y}, 4'b0001);
    #10 check("low65_state", dut.present_state, 4'b1000);    // t=68
        check("low65_y", {3'b000, Y}, 4'b0000);
    // Second falling edge
    #5  I = 1'b1;                                             // t=73
    #5  check("high75_state", dut.present_state, 4'b0010);   // t=78
    #15 I = 1'b0;                                             // t=93
    #5  check("fall95_state", dut.present_state, 4'b0100);   // t=98
        check("fall95_y", {3'b000, Y}, 4'b0001);
    #10 check("low105_state", dut.present_state, 4'b1000);   // t=108
        check("low105_y", {3'b000, Y}, 4'b0000);

    // Low out of reset: never a pulse
    drive(1'b0, 1'b1);
    peek("lowrst_idle", 4'b0001, 1'b0);
    drive(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) peek("lowrst_hold", 4'b1000, 1'b0);

    // Alternating 1,0,1,0 at consecutive edges
    drive(1'b1, 1'b0); peek("alt1", 4'b0010, 1'b0);
    drive(1'b0, 1'b0); peek("alt2", 4'b0100, 1'b1);
    drive(1'b1, 1'b0); peek("alt3", 4'b0010, 1'b0);
    drive(1'b0, 1'b0); peek("alt4", 4'b0100, 1'b1);

    // Reset asserted while in FALL ends the pulse at that edge
    drive(1'b1, 1'b0); peek("rp_high", 4'b0010, 1'b0);
    drive(1'b0, 1'b0); peek("rp_fall", 4'b0100, 1'b1);
    drive(1'b0, 1'b1); peek("rp_reset", 4'b0001, 1'b0);

    // Randomized level input with occasional resets
    for (int i = 0; i < 400; i++) begin
      drive(1'(($urandom_range(0, 1))), ($urandom_range(0, 19) == 0));
    end

    // Illegal state injection: multi-hot code must recover to IDLE
    drive(1'b1, 1'b0);
    @(posedge clk);
    #2;
    force dut.present_state = 4'b0110;
    inj_on = 1'b1;
    #1;
    check("illegal_y", {3'b000, Y}, 4'b0000);
    release dut.present_state;
    @(posedge clk);
    #1 inj_on = 1'b0;
    #1;
    check("illegal_recover_state", dut.present_state, 4'b0001);
    check("illegal_recover_y", {3'b000, Y}, 4'b0000);
    drive(1'b0, 1'b0);
    peek("post_illegal", 4'b1000, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
